bus_ctrl_decoder: RTL and testbench
===================================

BUS_CTRL_DECODER -- requirements
Module: bus_ctrl_decoder

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting masters (2..4).
REQ-002 SHALL have parameter NUM_SLAVES, default 3, number of slaves (1..2^SLV_W-1).
REQ-003 SHALL have parameter SLV_W, default 2, width of the slave-select field.
REQ-004 SHALL have parameter ADDR_W, default 7, width of the slave address field.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS watchdog limit (used only with BUS_TIMEOUT_EN).
REQ-006 SHALL have derived REQ_W = SLV_W+1+ADDR_W and MSEL_W = clog2(NUM_MASTERS) (minimum 1).
REQ-007 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst.
REQ-008 clk  input  1  rising-edge clock for all state.
REQ-009 rst  input  1  asynchronous active-low reset.
REQ-010 m_req  input  NUM_MASTERS*REQ_W  packed master words; master i occupies slice i; per word, [REQ_W-1:ADDR_W+1] = slave code, [ADDR_W] = rw (1 = write), [ADDR_W-1:0] = address.
REQ-011 m_valid  input  NUM_MASTERS  per-master request-valid flag.
REQ-012 master_select  input  MSEL_W  granted master index from the arbitrator.
REQ-013 s_ready  input  NUM_SLAVES  per-slave access-complete flag.
REQ-014 address_slave  output  ADDR_W  registered slave address.
REQ-015 wen / ren  output  NUM_SLAVES each  registered per-slave write/read enables, at most one bit set across both.
REQ-016 m_done / m_err  output  NUM_MASTERS each  one-cycle completion / error pulses to the owning master.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, DECODE, ACCESS.
REQ-019 IDLE: if m_valid[master_select]=1, SHALL capture that master's word and index, then go to DECODE; otherwise stay in IDLE.
REQ-020 Decode mapping: slave index = (2^SLV_W-1) - code; the code is valid only if the index < NUM_SLAVES (defaults: 11->slave0, 10->slave1, 01->slave2, 00->invalid).
REQ-021 DECODE, valid code: SHALL register address_slave, set wen[idx] if rw=1 else ren[idx], then go to ACCESS.
REQ-022 DECODE, invalid code: SHALL drive no enables, pulse m_err[captured master] for one cycle, then return to IDLE.
REQ-023 Enables SHALL be high only while in ACCESS; the request-to-enable latency is exactly 2 clock edges.
REQ-024 ACCESS: on the edge where s_ready[idx]=1, SHALL clear all enables, pulse m_done[captured master] for one cycle, and return to IDLE.
REQ-025 s_ready bits of non-selected slaves SHALL be ignored.
REQ-026 Changes to master_select, m_req or m_valid outside IDLE SHALL have no effect on the transaction in flight.
REQ-027 Back-to-back transactions SHALL be allowed: IDLE may capture a new request in the same cycle m_done is high, giving a minimum of 3 cycles per transaction.
REQ-028 address_slave SHALL hold its last value between transactions.
REQ-029 master_select values >= NUM_MASTERS SHALL be treated as no request.

Reset
REQ-030 On rst=0, the block SHALL asynchronously force the FSM to IDLE and clear address_slave, wen, ren, m_done, m_err, busy, any captured word and the timeout counter.
REQ-031 A reset asserted mid-transaction SHALL drop that transaction with no m_done or m_err pulse.
REQ-032 After rst deasserts, the first capture SHALL occur no earlier than the first rising edge of clk.

Configuration
REQ-033 With macro BUS_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry and increment each ACCESS cycle.
REQ-034 With BUS_TIMEOUT_EN defined, if TIMEOUT_CYCLES ACCESS cycles elapse without s_ready[idx], the block SHALL clear the enables, pulse m_err[captured master] and return to IDLE.
REQ-035 With BUS_TIMEOUT_EN defined, if s_ready and expiry coincide, s_ready SHALL win and m_done SHALL be pulsed.
REQ-036 Without BUS_TIMEOUT_EN, no counter SHALL exist, ACCESS SHALL wait indefinitely, and TIMEOUT_CYCLES SHALL be ignored.

Verification
REQ-037 Defaults, master_select=1, m_valid=2'b10, master1 word = 11_1_0010101 -> wen=3'b001 two edges later, address_slave=7'h15; s_ready[0] pulsed -> enables clear and m_done=2'b10 for one cycle.
REQ-038 master0 word = 01_0_1111111, s_ready[2] tied high -> ren=3'b100 for exactly one cycle, then m_done=2'b01.
REQ-039 Slave code 00 -> no enable asserted, m_err pulses for the requesting master, busy high for exactly 2 cycles.
REQ-040 rst driven low during ACCESS -> all outputs 0 immediately and no done/err pulse; a new request after release completes normally.
REQ-041 BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, s_ready held low -> enable high 4 cycles, then m_err pulse and return to IDLE; without the macro -> enable stays high for 100+ cycles.
REQ-042 Continuous valid requests alternating masters -> one transaction per 3 cycles, enables never overlap, and each m_done is attributed to the correct master.

Source files
------------

// File: rtl/bus_ctrl_decoder.sv
// Bus control decoder: captures the granted master's request, decodes the slave code and
// holds one registered enable until that slave completes. Optional ACCESS watchdog: BUS_TIMEOUT_EN.
module bus_ctrl_decoder #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int SLV_W          = 2,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int REQ_W  = SLV_W + 1 + ADDR_W,
  localparam int MSEL_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MASTERS*REQ_W-1:0] m_req,
  input  logic [NUM_MASTERS-1:0]       m_valid,
  input  logic [MSEL_W-1:0]            master_select,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [ADDR_W-1:0]            address_slave,
  output logic [NUM_SLAVES-1:0]        wen,
  output logic [NUM_SLAVES-1:0]        ren,
  output logic [NUM_MASTERS-1:0]       m_done,
  output logic [NUM_MASTERS-1:0]       m_err,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECODE = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [REQ_W-1:0]       word_r;
  logic [REQ_W-1:0]       word_next_s;
  logic [MSEL_W-1:0]      owner_r;
  logic [MSEL_W-1:0]      owner_next_s;
  logic [ADDR_W-1:0]      addr_next_s;
  logic [NUM_SLAVES-1:0]  wen_next_s;
  logic [NUM_SLAVES-1:0]  ren_next_s;
  logic [NUM_MASTERS-1:0] done_next_s;
  logic [NUM_MASTERS-1:0] err_next_s;
  logic                   busy_next_s;

  logic                   req_hit_s;
  logic [REQ_W-1:0]       sel_word_s;
  logic [SLV_W-1:0]       slv_idx_s;
  logic                   code_ok_s;
  logic                   rw_s;
  logic [NUM_SLAVES-1:0]  slv_onehot_s;
  logic                   sel_ready_s;
  logic [NUM_MASTERS-1:0] owner_onehot_s;
  logic                   timeout_s;

  // Slave index is the bitwise complement of the code, i.e. (2^SLV_W-1) - code.
  assign slv_idx_s   = ~word_r[REQ_W-1:ADDR_W+1];
  assign rw_s        = word_r[ADDR_W];
  assign code_ok_s   = ({1'b0, slv_idx_s} < (SLV_W+1)'(NUM_SLAVES));
  assign sel_ready_s = |(s_ready & slv_onehot_s);

  // Mux the granted master's word; out-of-range selects match nothing.
  always_comb begin
    req_hit_s  = 1'b0;
    sel_word_s = {REQ_W{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req_hit_s  = req_hit_s | (m_valid[i] & (master_select == MSEL_W'(i)));
      sel_word_s = sel_word_s | ({REQ_W{master_select == MSEL_W'(i)}} & m_req[i*REQ_W +: REQ_W]);
    end
  end

  // One-hot views of the captured slave index and owning master.
  always_comb begin
    slv_onehot_s   = {NUM_SLAVES{1'b0}};
    owner_onehot_s = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slv_onehot_s[i] = (slv_idx_s == SLV_W'(i));
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      owner_onehot_s[i] = (owner_r == MSEL_W'(i));
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_r;

  // Watchdog counter: zero outside ACCESS, counts each ACCESS cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ACCESS) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end
  end

  assign timeout_s = (state_r == ACCESS) && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: the comparison is constant false, so ACCESS waits indefinitely.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_next_s = state_r;
    word_next_s  = word_r;
    owner_next_s = owner_r;
    addr_next_s  = address_slave;
    wen_next_s   = wen;
    ren_next_s   = ren;
    done_next_s  = {NUM_MASTERS{1'b0}};
    err_next_s   = {NUM_MASTERS{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_hit_s) begin
          word_next_s  = sel_word_s;
          owner_next_s = master_select;
          state_next_s = DECODE;
        end else begin
          state_next_s = IDLE;
        end
      end
      DECODE: begin
        if (code_ok_s) begin
          addr_next_s = word_r[ADDR_W-1:0];
          if (rw_s) begin
            wen_next_s = slv_onehot_s;
          end else begin
            ren_next_s = slv_onehot_s;
          end
          state_next_s = ACCESS;
        end else begin
          err_next_s   = owner_onehot_s;
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (sel_ready_s) begin
          wen_next_s   = {NUM_SLAVES{1'b0}};
          ren_next_s   = {NUM_SLAVES{1'b0}};
          done_next_s  = owner_onehot_s;
          state_next_s = IDLE;
        end else if (timeout_s) begin
          wen_next_s   = {NUM_SLAVES{1'b0}};
          ren_next_s   = {NUM_SLAVES{1'b0}};
          err_next_s   = owner_onehot_s;
          state_next_s = IDLE;
        end else begin
          state_next_s = ACCESS;
        end
      end
      default: begin
        wen_next_s   = {NUM_SLAVES{1'b0}};
        ren_next_s   = {NUM_SLAVES{1'b0}};
        state_next_s = IDLE;
      end
    endcase
    // Busy covers the whole transaction including its final response pulse.
    busy_next_s = (state_next_s != IDLE) | (|done_next_s) | (|err_next_s);
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      word_r        <= {REQ_W{1'b0}};
      owner_r       <= {MSEL_W{1'b0}};
      address_slave <= {ADDR_W{1'b0}};
      wen           <= {NUM_SLAVES{1'b0}};
      ren           <= {NUM_SLAVES{1'b0}};
      m_done        <= {NUM_MASTERS{1'b0}};
      m_err         <= {NUM_MASTERS{1'b0}};
      busy          <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      word_r        <= word_next_s;
      owner_r       <= owner_next_s;
      address_slave <= addr_next_s;
      wen           <= wen_next_s;
      ren           <= ren_next_s;
      m_done        <= done_next_s;
      m_err         <= err_next_s;
      busy          <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_bus_ctrl_decoder.sv
// Randomised scoreboard bench for bus_ctrl_decoder: a transaction-level model predicts
// enables, address, busy and completion pulses; a negedge monitor compares them.
module tb_bus_ctrl_decoder;
  localparam int NM  = 2;
  localparam int NS  = 3;
  localparam int SW  = 2;
  localparam int AW  = 7;
  localparam int TMO = 4;
  localparam int RW  = SW + 1 + AW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NM*RW-1:0] m_req = '0;
  logic [NM-1:0]    m_valid = '0;
  logic [0:0]       master_select = '0;
  logic [NS-1:0]    s_ready = '0;
  logic [AW-1:0]    address_slave;
  logic [NS-1:0]    wen, ren;
  logic [NM-1:0]    m_done, m_err;
  logic             busy;

  bus_ctrl_decoder #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLV_W(SW), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_valid(m_valid), .master_select(master_select),
    .s_ready(s_ready), .address_slave(address_slave), .wen(wen), .ren(ren),
    .m_done(m_done), .m_err(m_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int code, input bit rw, input int addr);
    logic [SW-1:0] c;
    logic [AW-1:0] a;
    c = code[SW-1:0];
    a = addr[AW-1:0];
    return {c, rw, a};
  endfunction

  typedef struct {
    int master;
    bit err;
  } resp_t;
  resp_t exp_q[$];

  // Transaction-level reference: one request in flight, ages counted in clock edges.
  bit            mdl_busy = 1'b0;
  int            mdl_age, mdl_master, mdl_slave, mdl_addr, mdl_ms;
  bit            mdl_ok, mdl_rw, mdl_fin, mdl_ferr;
  logic [RW-1:0] mdl_word;
  logic [NS-1:0] exp_wen = '0, exp_ren = '0;
  logic [AW-1:0] exp_addr = '0;
  bit            exp_busy = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_busy = 1'b0;
      exp_wen  = '0;
      exp_ren  = '0;
      exp_addr = '0;
      exp_busy = 1'b0;
      exp_q.delete();
    end else begin
      mdl_fin  = 1'b0;
      mdl_ferr = 1'b0;
      if (mdl_busy) begin
        mdl_age++;
        if (!mdl_ok) begin
          mdl_fin  = 1'b1;
          mdl_ferr = 1'b1;
        end else if (mdl_age == 1) begin
          exp_addr = AW'(mdl_addr);
        end else if (s_ready[mdl_slave]) begin
          mdl_fin = 1'b1;
`ifdef BUS_TIMEOUT_EN
        end else if (mdl_age == TMO + 1) begin
          mdl_fin  = 1'b1;
          mdl_ferr = 1'b1;
`endif
        end
        if (mdl_fin) begin
          mdl_busy = 1'b0;
          exp_q.push_back('{mdl_master, mdl_ferr});
        end
      end else begin
        mdl_ms = int'(master_select);
        if (mdl_ms < NM && m_valid[mdl_ms]) begin
          mdl_word   = m_req[mdl_ms*RW +: RW];
          mdl_master = mdl_ms;
          mdl_slave  = (2**SW - 1) - int'(mdl_word[RW-1:AW+1]);
          mdl_ok     = (mdl_slave < NS);
          mdl_rw     = mdl_word[AW];
          mdl_addr   = int'(mdl_word[AW-1:0]);
          mdl_age    = 0;
          mdl_busy   = 1'b1;
        end
      end
      exp_wen = '0;
      exp_ren = '0;
      if (mdl_busy && mdl_ok && mdl_age >= 1) begin
        if (mdl_rw) exp_wen[mdl_slave] = 1'b1;
        else        exp_ren[mdl_slave] = 1'b1;
      end
      exp_busy = mdl_busy || mdl_fin;
    end
  end

  // Monitor: compares every output on the falling edge while out of reset.
  resp_t         mon_r;
  logic [NM-1:0] exp_done, exp_err;
  always @(negedge clk) begin
    if (rst) begin
      exp_done = '0;
      exp_err  = '0;
      if (exp_q.size() > 0) begin
        mon_r = exp_q.pop_front();
        if (mon_r.err) exp_err[mon_r.master] = 1'b1;
        else           exp_done[mon_r.master] = 1'b1;
      end
      check("m_done", 32'(m_done), 32'(exp_done));
      check("m_err", 32'(m_err), 32'(exp_err));
      check("wen", 32'(wen), 32'(exp_wen));
      check("ren", 32'(ren), 32'(exp_ren));
      check("busy", 32'(busy), 32'(exp_busy));
      check("address_slave", 32'(address_slave), 32'(exp_addr));
      check("enable_onehot", 32'($countones({wen, ren}) <= 1), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input int ms, input int code, input bit rw, input int addr);
    master_select = 1'(ms);
    m_valid = '0;
    m_valid[ms] = 1'b1;
    m_req[ms*RW +: RW] = mk(code, rw, addr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(address_slave), 32'd0);
    check({tag, "_wen"}, 32'(wen), 32'd0);
    check({tag, "_ren"}, 32'(ren), 32'd0);
    check({tag, "_done"}, 32'(m_done), 32'd0);
    check({tag, "_err"}, 32'(m_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    step(3);
    check_all_zero("reset");
    rst = 1'b1;
    step(2);

    // Master 1 writes slave 0 at 0x15; slave completes later.
    request(1, 3, 1'b1, 'h15);
    step(1);
    m_valid = '0;
    step(1);
    check("req037_wen", 32'(wen), 32'd1);
    check("req037_addr", 32'(address_slave), 32'h15);
    step(2);
    s_ready = 3'b001;
    step(1);
    s_ready = 3'b000;
    step(2);

    // Master 0 reads slave 2 with its ready tied high.
    request(0, 1, 1'b0, 'h7f);
    s_ready = 3'b100;
    step(1);
    m_valid = '0;
    step(4);
    s_ready = 3'b000;

    // Invalid code 00 from master 1.
    request(1, 0, 1'b1, 'h2a);
    step(1);
    m_valid = '0;
    step(4);

    // Long ACCESS with the selected ready low; other readies toggle and must be ignored.
    request(0, 2, 1'b1, 'h33);
    step(1);
    m_valid = '0;
    for (int i = 0; i < 110; i++) begin
      s_ready = (i % 2 == 0) ? 3'b101 : 3'b000;
      step(1);
    end
    s_ready = 3'b000;
`ifdef BUS_TIMEOUT_EN
    check("hold_wen", 32'(wen), 32'd0);
`else
    check("hold_wen", 32'(wen), 32'b010);
`endif
    s_ready = 3'b010;
    step(1);
    s_ready = 3'b000;
    step(2);

    // Reset in the middle of ACCESS.
    request(1, 3, 1'b0, 'h11);
    step(1);
    m_valid = '0;
    step(3);
    #2 rst = 1'b0;
    #1 check_all_zero("midreset");
    step(2);
    rst = 1'b1;
    step(1);
    request(0, 2, 1'b0, 'h44);
    step(1);
    m_valid = '0;
    step(2);
    s_ready = 3'b010;
    step(1);
    s_ready = 3'b000;
    step(2);

    // Back-to-back traffic from alternating masters, every slave ready.
    m_valid = 2'b11;
    s_ready = 3'b111;
    for (int i = 0; i < 60; i++) begin
      master_select = 1'(i % 2);
      for (int m = 0; m < NM; m++) begin
        m_req[m*RW +: RW] = mk(1 + int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                               int'($urandom_range(0, 127)));
      end
      step(1);
    end

    // Fully random traffic.
    for (int i = 0; i < 1500; i++) begin
      master_select = 1'($urandom_range(0, 1));
      m_valid = 2'($urandom_range(0, 3));
      for (int m = 0; m < NM; m++) begin
        m_req[m*RW +: RW] = mk(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                               int'($urandom_range(0, 127)));
      end
      s_ready = 3'($urandom_range(0, 7));
      step(1);
    end

    m_valid = '0;
    s_ready = 3'b111;
    step(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
